// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the 5-stage RISC-V pipeline fetch stage:
//   - XLEN          datapath width
//   - fetch_state_t fetch controller states (BOOT, RUN, TRAP)
//   - RESET_PC      PC value loaded on reset
//   - TRAP_VEC      fetch address taken on a misaligned redirect
//   - NOP_INSTR     instruction word used for pipeline bubbles (addi x0,x0,0)
package pipeline_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_pc_fetch_ifid_reg.sv
// ifid_reg
// IF/ID pipeline register. Holds the PC, PC+4 and instruction word of the
// instruction handed to decode, plus a valid bit.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   load_i          capture pc_i/pc4_i/instr_i as a valid instruction
//   bubble_i        replace contents with a bubble (wins over load_i)
//   pc_i, pc4_i     PC and PC+4 of the fetched word
//   instr_i         fetched instruction word
//   pc_o, pc4_o     registered PC / PC+4 (zero for a bubble)
//   instr_o         registered instruction (NOP_INSTR for a bubble)
//   valid_o         register holds a real instruction
module ifid_reg
    import pipeline_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            bubble_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc4_i,
    input  logic [XLEN-1:0] instr_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc4_o,
    output logic [XLEN-1:0] instr_o,
    output logic            valid_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc4_q;
    logic [XLEN-1:0] instr_q;
    logic            valid_q;

    // With neither load nor bubble the register holds, which is how a stall
    // freezes decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            pc4_q   <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (bubble_i) begin
            pc_q    <= '0;
            pc4_q   <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (load_i) begin
            pc_q    <= pc_i;
            pc4_q   <= pc4_i;
            instr_q <= instr_i;
            valid_q <= 1'b1;
        end
    end

    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_pc_fetch.sv
// if_pc_fetch
// Fetch-stage PC, fetch controller and IF/ID register. Drives the instruction
// memory address from the PC register, latches the fetched word into IF/ID,
// takes execute-stage redirects and traps misaligned redirect targets.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   stall             hazard-unit hold of PC and IF/ID
//   redirect_valid    EX stage branch taken / jump
//   redirect_target   EX target adder result
//   imem_addr         instruction memory address (= PC register)
//   imem_rdata        instruction word at imem_addr, same cycle
//   ifid_pc/_pc4      PC and PC+4 of the instruction in IF/ID
//   ifid_instr        instruction in IF/ID
//   ifid_valid        IF/ID holds a real instruction
//   flush             kill the instruction currently in ID
//   exc_misaligned    one-cycle pulse after a misaligned redirect
//   exc_addr          offending target, held until the next trap
module if_pc_fetch
    import pipeline_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc4,
    output logic [XLEN-1:0] ifid_instr,
    output logic            ifid_valid,
    output logic            flush,
    output logic            exc_misaligned,
    output logic [XLEN-1:0] exc_addr
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] exc_addr_q, exc_addr_d;
    logic [XLEN-1:0] pc_plus4;
    logic            ifid_load;
    logic            ifid_bubble;

    // Modulo-2^32 increment: 0xFFFF_FFFC wraps to 0 silently.
    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            exc_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            exc_addr_q <= exc_addr_d;
        end
    end

    // Redirect is only honoured in RUN, and always beats stall there. TRAP is
    // an ordinary fetch cycle at TRAP_VEC that also raises the exception pulse;
    // it ignores redirects because the redirecting instruction is the one that
    // trapped.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        exc_addr_d     = exc_addr_q;
        ifid_load      = 1'b0;
        ifid_bubble    = 1'b0;
        flush          = 1'b0;
        exc_misaligned = 1'b0;
        case (state_q)
            ST_BOOT: begin
                ifid_bubble = 1'b1;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                flush = redirect_valid;
                if (redirect_valid) begin
                    ifid_bubble = 1'b1;
                    if (redirect_target[1:0] == 2'b00) begin
                        pc_d = redirect_target;
                    end else begin
                        pc_d       = TRAP_VEC;
                        exc_addr_d = redirect_target;
                        state_d    = ST_TRAP;
                    end
                end else if (!stall) begin
                    pc_d      = pc_plus4;
                    ifid_load = 1'b1;
                end
            end
            ST_TRAP: begin
                exc_misaligned = 1'b1;
                state_d        = ST_RUN;
                if (!stall) begin
                    pc_d      = pc_plus4;
                    ifid_load = 1'b1;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    ifid_reg u_ifid_reg (
        .clk      (clk),
        .rst      (rst),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .pc_i     (pc_q),
        .pc4_i    (pc_plus4),
        .instr_i  (imem_rdata),
        .pc_o     (ifid_pc),
        .pc4_o    (ifid_pc4),
        .instr_o  (ifid_instr),
        .valid_o  (ifid_valid)
    );

    assign imem_addr = pc_q;
    assign exc_addr  = exc_addr_q;

endmodule

// File: tb/tb_if_pc_fetch.sv
// tb_if_pc_fetch
// Directed, table-driven bench for if_pc_fetch. Each table row is one clock
// cycle: the inputs driven in that cycle and the outputs expected in it.
// Instruction memory returns its address XORed with a tag so PC and
// instruction fields of IF/ID can be told apart.
module tb_if_pc_fetch;
    import pipeline_pkg::*;

    localparam logic [31:0] TAG = 32'hCAFE_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        flush;
    logic        exc_misaligned;
    logic [31:0] exc_addr;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rt;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expPc;
        logic        expFlush;
        logic        expExc;
        logic [31:0] expExcAddr;
    } vec_t;

    vec_t vecs[$];

    if_pc_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .ifid_pc         (ifid_pc),
        .ifid_pc4        (ifid_pc4),
        .ifid_instr      (ifid_instr),
        .ifid_valid      (ifid_valid),
        .flush           (flush),
        .exc_misaligned  (exc_misaligned),
        .exc_addr        (exc_addr)
    );

    // Tagged address echo standing in for instruction memory.
    assign imem_rdata = imem_addr ^ TAG;

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a failure line on mismatch.
    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic st, input logic rv, input logic [31:0] rt,
                          input logic [31:0] addr, input logic valid, input logic [31:0] pc,
                          input logic fl, input logic exc, input logic [31:0] excAddr);
        vec_t v;
        v.stall      = st;
        v.rv         = rv;
        v.rt         = rt;
        v.expAddr    = addr;
        v.expValid   = valid;
        v.expPc      = pc;
        v.expFlush   = fl;
        v.expExc     = exc;
        v.expExcAddr = excAddr;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        stall           = v.stall;
        redirect_valid  = v.rv;
        redirect_target = v.rt;
    endtask

    // Bubble contents are fixed; a valid entry's pc4 and instruction follow
    // from its PC and the memory tag.
    task automatic checkOutput(input vec_t v, input string tagName);
        logic [31:0] expPc4;
        logic [31:0] expInstr;
        expPc4   = v.expValid ? v.expPc + 32'd4 : 32'd0;
        expInstr = v.expValid ? (v.expPc ^ TAG) : NOP_INSTR;
        checkVal({tagName, ".imem_addr"}, imem_addr, v.expAddr);
        checkVal({tagName, ".ifid_valid"}, {31'd0, ifid_valid}, {31'd0, v.expValid});
        checkVal({tagName, ".ifid_pc"}, ifid_pc, v.expValid ? v.expPc : 32'd0);
        checkVal({tagName, ".ifid_pc4"}, ifid_pc4, expPc4);
        checkVal({tagName, ".ifid_instr"}, ifid_instr, expInstr);
        checkVal({tagName, ".flush"}, {31'd0, flush}, {31'd0, v.expFlush});
        checkVal({tagName, ".exc_misaligned"}, {31'd0, exc_misaligned}, {31'd0, v.expExc});
        checkVal({tagName, ".exc_addr"}, exc_addr, v.expExcAddr);
    endtask

    // Called at a falling edge: drive the row, sample 1 ns later, then move
    // on to the next falling edge (the rising edge falls in between).
    task automatic runVectors(input string prefix);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i], $sformatf("%s%0d", prefix, i));
            @(negedge clk);
        end
    endtask

    initial begin
        rst             = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;

        // Reset state, checked while reset is still asserted.
        @(negedge clk);
        checkVal("reset.imem_addr", imem_addr, RESET_PC);
        checkVal("reset.ifid_valid", {31'd0, ifid_valid}, 32'd0);
        checkVal("reset.ifid_instr", ifid_instr, NOP_INSTR);
        checkVal("reset.ifid_pc", ifid_pc, 32'd0);
        checkVal("reset.flush", {31'd0, flush}, 32'd0);
        checkVal("reset.exc_misaligned", {31'd0, exc_misaligned}, 32'd0);
        checkVal("reset.exc_addr", exc_addr, 32'd0);

        //     stall rv  target        addr          valid pc            flush exc excAddr
        addVec(1'b0, 1'b0, 32'h0,      32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0);   // BOOT
        addVec(1'b0, 1'b0, 32'h0,      32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0);   // first fetch
        addVec(1'b0, 1'b0, 32'h0,      32'h4,        1'b1, 32'h0,        1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b0, 32'h0,      32'h8,        1'b1, 32'h4,        1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b0, 32'h0,      32'hC,        1'b1, 32'h8,        1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 32'h0,      32'h10,       1'b1, 32'hC,        1'b0, 1'b0, 32'h0);   // stall x3
        addVec(1'b1, 1'b0, 32'h0,      32'h10,       1'b1, 32'hC,        1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 32'h0,      32'h10,       1'b1, 32'hC,        1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b0, 32'h0,      32'h10,       1'b1, 32'hC,        1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b0, 32'h0,      32'h14,       1'b1, 32'h10,       1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b0, 32'h0,      32'h18,       1'b1, 32'h14,       1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b0, 32'h0,      32'h1C,       1'b1, 32'h18,       1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b1, 32'h200,    32'h20,       1'b1, 32'h1C,       1'b1, 1'b0, 32'h0);   // redirect
        addVec(1'b0, 1'b0, 32'h0,      32'h200,      1'b0, 32'h0,        1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b0, 32'h0,      32'h204,      1'b1, 32'h200,      1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b1, 32'h40,     32'h208,      1'b1, 32'h204,      1'b1, 1'b0, 32'h0);   // redirect + stall
        addVec(1'b0, 1'b0, 32'h0,      32'h40,       1'b0, 32'h0,        1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b0, 32'h0,      32'h44,       1'b1, 32'h40,       1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b1, 32'h202,    32'h48,       1'b1, 32'h44,       1'b1, 1'b0, 32'h0);   // misaligned
        addVec(1'b0, 1'b1, 32'h300,    32'h100,      1'b0, 32'h0,        1'b0, 1'b1, 32'h202); // TRAP, redirect ignored
        addVec(1'b0, 1'b0, 32'h0,      32'h104,      1'b1, 32'h100,      1'b0, 1'b0, 32'h202);
        addVec(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h108,   1'b1, 32'h104,      1'b1, 1'b0, 32'h202);
        addVec(1'b0, 1'b0, 32'h0,      32'hFFFF_FFFC, 1'b0, 32'h0,       1'b0, 1'b0, 32'h202);
        addVec(1'b0, 1'b0, 32'h0,      32'h0,        1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h202); // wrap
        addVec(1'b0, 1'b1, 32'h3,      32'h4,        1'b1, 32'h0,        1'b1, 1'b0, 32'h202); // misaligned again
        addVec(1'b1, 1'b0, 32'h0,      32'h100,      1'b0, 32'h0,        1'b0, 1'b1, 32'h3);   // TRAP under stall
        addVec(1'b0, 1'b0, 32'h0,      32'h100,      1'b0, 32'h0,        1'b0, 1'b0, 32'h3);
        addVec(1'b0, 1'b0, 32'h0,      32'h104,      1'b1, 32'h100,      1'b0, 1'b0, 32'h3);

        // Release reset on a falling edge so the first row is the BOOT cycle.
        rst = 1'b0;
        runVectors("v");

        // Mid-run asynchronous reset, asserted away from any clock edge with a
        // redirect pending: everything clears at once and flush drops.
        redirect_valid  = 1'b1;
        redirect_target = 32'h500;
        #2;
        rst = 1'b1;
        #1;
        checkVal("midreset.imem_addr", imem_addr, RESET_PC);
        checkVal("midreset.ifid_valid", {31'd0, ifid_valid}, 32'd0);
        checkVal("midreset.ifid_instr", ifid_instr, NOP_INSTR);
        checkVal("midreset.ifid_pc", ifid_pc, 32'd0);
        checkVal("midreset.ifid_pc4", ifid_pc4, 32'd0);
        checkVal("midreset.flush", {31'd0, flush}, 32'd0);
        checkVal("midreset.exc_addr", exc_addr, 32'd0);
        redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Restart after reset: BOOT, then fetch from RESET_PC again.
        vecs.delete();
        addVec(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b0, 32'h0, 32'h4, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        runVectors("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_pc_fetch.md
# if_pc_fetch

Fetch-stage program-counter and IF/ID pipeline-register block for the 5-stage RISC-V pipeline. Holds the architectural fetch PC, drives the instruction-memory address, and latches the fetched word into the IF/ID register. It consumes the branch/jump target produced by the execute-stage target adder (pc + extimm), redirects fetch on a taken control transfer, and traps misaligned targets. Hazard-unit stall and execute-stage redirect are arbitrated here.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- TRAP_VEC, 32'h0000_0100, fetch address on a misaligned redirect
- NOP_INSTR, 32'h0000_0013, instruction word inserted for bubbles (addi x0,x0,0)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hazard-unit hold of PC and IF/ID
- redirect_valid  in  1  EX stage: branch taken or jump
- redirect_target  in  32  target from the EX target adder
- imem_addr  out  32  instruction-memory address (combinational read)
- imem_rdata  in  32  instruction word for imem_addr, same cycle
- ifid_pc  out  32  PC of the instruction in IF/ID
- ifid_pc4  out  32  ifid_pc + 4
- ifid_instr  out  32  instruction in IF/ID
- ifid_valid  out  1  IF/ID holds a real instruction
- flush  out  1  kill the ID-stage instruction (to ID/EX)
- exc_misaligned  out  1  one-cycle pulse: misaligned redirect trapped
- exc_addr  out  32  offending target, held until next trap

## Operation
- States: BOOT, RUN, TRAP. Reset → BOOT.
- BOOT: one cycle; imem_addr = RESET_PC; IF/ID keeps bubble; → RUN unconditionally (stall ignored).
- RUN, per cycle, in priority order:
  - redirect_valid & redirect_target[1:0] == 0: pc ← redirect_target; IF/ID ← bubble; flush = 1.
  - redirect_valid & misaligned: pc ← TRAP_VEC; IF/ID ← bubble; flush = 1; exc_addr ← redirect_target; → TRAP.
  - stall: pc, IF/ID unchanged; flush = 0.
  - else: pc ← pc + 4; IF/ID ← {pc, pc+4, imem_rdata, valid = 1}.
- TRAP: one cycle; exc_misaligned = 1; normal fetch from TRAP_VEC (stall honoured, redirect ignored); → RUN.
- Redirect beats stall in the same cycle.
- Bubble: ifid_instr = NOP_INSTR, ifid_valid = 0, ifid_pc and ifid_pc4 = 0.
- Arithmetic: 32-bit modulo; pc + 4 wraps 32'hFFFF_FFFC → 32'h0000_0000 with no flag.
- flush is combinational: redirect_valid & (state == RUN).

## Timing
- Reset values: pc = RESET_PC; imem_addr = RESET_PC; IF/ID bubble; flush = 0; exc_misaligned = 0; exc_addr = 0.
- Reset asserted mid-operation clears all state immediately, with no clock edge required.
- imem_addr = pc register (zero-latency read). The word fetched in cycle N appears on ifid_* in cycle N+1.
- Redirect in cycle N:
  - imem_addr = target in N+1.
  - IF/ID is a bubble in N+1.
  - The first target instruction is valid in IF/ID in N+2.
- Penalty is two slots: the IF slot is squashed here, and the ID slot is squashed by flush.
- Misaligned redirect in cycle N:
  - exc_misaligned pulses in N+1.
  - imem_addr = TRAP_VEC in N+1.

## Structure
- Shared package pipeline_pkg:
  - state encoding BOOT/RUN/TRAP
  - NOP_INSTR
  - width constant XLEN = 32
- The IF/ID register is a natural sub-module, ifid_reg, with inputs load, bubble, pc, pc4, and instr.
- The PC / FSM logic stays in the top module.

## Test plan
- Reset release, no stall, imem_rdata = address echo:
  - BOOT cycle at 0x0.
  - imem_addr then 0x0, 0x4, 0x8.
  - ifid_pc follows one cycle later with ifid_valid = 1.
- Stall held 3 cycles at pc = 0x10: imem_addr and ifid_* frozen, then resume at 0x14.
- redirect_valid with target 0x200 at pc = 0x20:
  - flush = 1 in the same cycle.
  - Next cycle imem_addr = 0x200 and ifid_valid = 0.
  - Following cycle ifid_pc = 0x200.
- redirect_valid and stall together, target 0x40: redirect wins, pc = 0x40 next cycle.
- Misaligned target 0x202:
  - pc = 0x100 next cycle.
  - exc_misaligned pulses once.
  - exc_addr = 0x202.
  - A redirect during TRAP is ignored.
- pc = 0xFFFF_FFFC running: wraps to 0x0. rst pulse mid-run: immediate pc = RESET_PC, bubble, flush = 0.
